sha256_round_engine: RTL and testbench
======================================

Name: sha256_round_engine

Overview:
- Downstream consumer of the K-constant stage: takes the current round constant (cur_k_value) plus the matching message-schedule word and runs the 64 SHA-256 compression rounds on one 512-bit block.
- Adds the final working variables into the incoming chaining value and presents the 256-bit intermediate hash with a completion flag.
- Sits between the K/W supply stages and the top-level hash controller.

Parameters:
- ROUNDS, 64, number of compression rounds; the round index width is $clog2(ROUNDS).
- WORD, 32, word width; fixed at 32 for SHA-256 and not meant to be overridden.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  block enable; low forces a synchronous abort to IDLE
- start  input  1  one-cycle request to begin a block; sampled only in IDLE
- h_in  input  256  chaining value H0..H7, H0 in bits [255:224]
- k_value  input  32  round constant for round_index
- w_value  input  32  schedule word for round_index
- in_valid  input  1  k_value and w_value are valid for round_index this cycle
- in_ready  output  1  engine accepts a round this cycle
- round_index  output  6  round currently requested (0..63)
- hash_out  output  256  H0'..H7', H0' in [255:224]
- hash_valid  output  1  one-cycle pulse when hash_out is first valid
- round_complete  output  1  level; high from hash_valid until the engine leaves DONE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; a..h, H0..H7, round_index, hash_out, hash_valid, round_complete and in_ready all 0.
- States:
  - IDLE -> ROUND on start&&enable. That same edge loads H0..H7 and a..h from h_in and sets round_index=0.
  - ROUND -> ADD on the edge that accepts round 63.
  - ADD -> DONE after one cycle.
  - DONE -> IDLE when enable=0.
- enable=0 in any state:
  - Next state is IDLE; round_index, hash_valid and round_complete clear.
  - hash_out holds its last value.
- in_ready = (state==ROUND) && enable. This output is combinational from state.
- Round acceptance (in_valid && in_ready):
  - T1 = h + S1(e) + Ch(e,f,g) + k_value + w_value; T2 = S0(a) + Maj(a,b,c). All sums are mod 2^32, with carries discarded.
  - h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
  - round_index increments.
  - One round per accepted cycle. in_valid low stalls the engine with all state held, for unbounded bubbles.
- Round functions:
  - S0(x) = ror2^ror13^ror22; S1(x) = ror6^ror11^ror25.
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
- round_index does not wrap: after round 63 is accepted, the state leaves ROUND, so index 64 is never presented and in_ready drops.
- ADD cycle: hash_out[i] <= H[i] + var[i] mod 2^32 for each of the 8 words.
- DONE entry: hash_valid=1 for exactly one cycle and round_complete=1 held.
- Latency: with in_valid held high, hash_valid rises 66 cycles after the start edge (64 rounds + ADD + register).
- Ignored inputs:
  - start outside IDLE is ignored.
  - start and enable rising on the same edge starts normally.
  - in_valid outside ROUND is ignored.
- Asynchronous reset mid-block discards all progress; there is no resumption.
- h_in is sampled only at the start edge and may change afterwards.

Decomposition:
- Package sha256_pkg holds:
  - WORD_W=32, ROUNDS=64, IV constants H0..H7.
  - The state enum (IDLE, ROUND, ADD, DONE).
  - Functions ror, big_sigma0, big_sigma1, ch, maj. These are shared with the schedule block, which needs ror.
- One sub-module, sha256_round_logic: purely combinational, a..h + k + w -> next a..h.
- The engine holds the FSM, counter and registers.

Test Plan:
- Standard IV, "abc" block (W0=0x61626380, W15=0x00000018, others 0) with full K table, in_valid tied high:
  - After round 0: a=0x5D6AEBCD, e=0xFA2A4622.
  - hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - hash_valid exactly 66 cycles after start.
- Same "abc" stimulus with in_valid toggling 1/0 pseudo-randomly:
  - Identical digest.
  - round_index advances only on accepted cycles.
  - hash_valid is a single-cycle pulse.
- Drop enable during round 30:
  - Engine goes to IDLE next edge; round_index=0; round_complete=0.
  - A fresh start then yields the correct "abc" digest.
- Assert reset=0 asynchronously mid-block (no clock edge):
  - All outputs 0 immediately.
  - After release, IDLE ignores in_valid until start.
- Pulse start while in ROUND and again in DONE:
  - No restart, and the registered a..h are unchanged by the pulse.
  - DONE holds round_complete=1 until enable=0.
- Chain a second block:
  - h_in = first digest, W = padded empty-string-style block as golden model.
  - Digest matches the software reference; the mod-2^32 wrap in ADD is exercised (H0+a overflow).

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and round helper functions used by the
// round engine and the message-schedule block.
package sha256_pkg;

    localparam int WORD_W   = 32;
    localparam int ROUNDS   = 64;
    localparam int NUM_VARS = 8;

    typedef logic [WORD_W-1:0] word_t;
    // Index 7 holds a (or H0), index 0 holds h (or H7), matching h_in packing.
    typedef logic [NUM_VARS-1:0][WORD_W-1:0] vars_t;

    localparam word_t IV_H0 = 32'h6a09e667;
    localparam word_t IV_H1 = 32'hbb67ae85;
    localparam word_t IV_H2 = 32'h3c6ef372;
    localparam word_t IV_H3 = 32'ha54ff53a;
    localparam word_t IV_H4 = 32'h510e527f;
    localparam word_t IV_H5 = 32'h9b05688c;
    localparam word_t IV_H6 = 32'h1f83d9ab;
    localparam word_t IV_H7 = 32'h5be0cd19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic word_t ror(input word_t x, input logic [4:0] n);
        ror = (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        big_sigma0 = ror(x, 5'd2) ^ ror(x, 5'd13) ^ ror(x, 5'd22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        big_sigma1 = ror(x, 5'd6) ^ ror(x, 5'd11) ^ ror(x, 5'd25);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        ch = (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        maj = (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round_logic.sv
// One SHA-256 compression round: working variables a..h plus K and W
// produce the next a..h. Purely combinational.
module sha256_round_logic
    import sha256_pkg::*;
(
    input  vars_t vars,
    input  word_t k_value,
    input  word_t w_value,
    output vars_t next_vars
);

    word_t t1_s;
    word_t t2_s;

    // Compute T1/T2 and shift the working variables down by one slot.
    always_comb begin
        t1_s = vars[0] + big_sigma1(vars[3]) + ch(vars[3], vars[2], vars[1])
             + k_value + w_value;
        t2_s = big_sigma0(vars[7]) + maj(vars[7], vars[6], vars[5]);
        next_vars = {t1_s + t2_s, vars[7], vars[6], vars[5],
                     vars[4] + t1_s, vars[3], vars[2], vars[1]};
    end

endmodule

// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: consumes one (K, W) pair per accepted cycle for
// 64 rounds, then folds the result into the chaining value.
module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64,
    parameter int WORD   = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        start,
    input  logic [8*WORD-1:0]           h_in,
    input  logic [WORD-1:0]             k_value,
    input  logic [WORD-1:0]             w_value,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [$clog2(ROUNDS)-1:0]   round_index,
    output logic [8*WORD-1:0]           hash_out,
    output logic                        hash_valid,
    output logic                        round_complete
);

    localparam int IDX_W = $clog2(ROUNDS);

    state_e            state_r;
    state_e            state_next_s;
    vars_t             work_r;
    vars_t             chain_r;
    vars_t             next_work_s;
    vars_t             hash_out_r;
    logic [IDX_W-1:0]  round_index_r;
    logic              hash_valid_r;
    logic              round_complete_r;
    logic              last_round_s;

    sha256_round_logic u_round_logic (
        .vars      (work_r),
        .k_value   (k_value),
        .w_value   (w_value),
        .next_vars (next_work_s)
    );

    assign last_round_s   = (round_index_r == IDX_W'(ROUNDS - 1));
    assign in_ready       = (state_r == ROUND) && enable;
    assign round_index    = round_index_r;
    assign hash_out       = hash_out_r;
    assign hash_valid     = hash_valid_r;
    assign round_complete = round_complete_r;

    // Next-state decode; dropping enable aborts to IDLE from any state.
    always_comb begin
        state_next_s = state_r;
        if (!enable) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_next_s = start ? ROUND : IDLE;
                ROUND:   state_next_s = (in_valid && last_round_s) ? ADD : ROUND;
                ADD:     state_next_s = DONE;
                DONE:    state_next_s = DONE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State, working variables, round counter and result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r          <= IDLE;
            work_r           <= '0;
            chain_r          <= '0;
            round_index_r    <= '0;
            hash_out_r       <= '0;
            hash_valid_r     <= 1'b0;
            round_complete_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (!enable) begin
                round_index_r    <= '0;
                hash_valid_r     <= 1'b0;
                round_complete_r <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        hash_valid_r     <= 1'b0;
                        round_complete_r <= 1'b0;
                        if (start) begin
                            chain_r       <= h_in;
                            work_r        <= h_in;
                            round_index_r <= '0;
                        end
                    end
                    ROUND: begin
                        if (in_valid) begin
                            work_r        <= next_work_s;
                            round_index_r <= last_round_s ? '0 : round_index_r + IDX_W'(1);
                        end
                    end
                    ADD: begin
                        for (int i = 0; i < NUM_VARS; i++) begin
                            hash_out_r[i] <= chain_r[i] + work_r[i];
                        end
                    end
                    DONE: begin
                        // Pulse only on the first DONE cycle; the level stays up.
                        hash_valid_r     <= !round_complete_r;
                        round_complete_r <= 1'b1;
                    end
                    default: begin
                        hash_valid_r     <= 1'b0;
                        round_complete_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Self-checking bench for sha256_round_engine against a software-style
// SHA-256 compression model with directed and randomized blocks.
module tb_sha256_round_engine;

    logic         clock    = 1'b0;
    logic         reset    = 1'b0;
    logic         enable   = 1'b0;
    logic         start    = 1'b0;
    logic         in_valid = 1'b0;
    logic [255:0] h_in     = '0;
    logic [31:0]  k_value;
    logic [31:0]  w_value;
    logic         in_ready;
    logic [5:0]   round_index;
    logic [255:0] hash_out;
    logic         hash_valid;
    logic         round_complete;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    logic [31:0] w_sched [64];

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIGEST = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    sha256_round_engine dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .start          (start),
        .h_in           (h_in),
        .k_value        (k_value),
        .w_value        (w_value),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .round_index    (round_index),
        .hash_out       (hash_out),
        .hash_valid     (hash_valid),
        .round_complete (round_complete)
    );

    // The upstream K and W stages answer whatever round the engine requests.
    assign k_value = k_tab[round_index];
    assign w_value = w_sched[round_index];

    always #5 clock = ~clock;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    task automatic set_block(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) w_sched[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w_sched[t] = (rotr(w_sched[t-2], 17) ^ rotr(w_sched[t-2], 19) ^ (w_sched[t-2] >> 10))
                       + w_sched[t-7]
                       + (rotr(w_sched[t-15], 7) ^ rotr(w_sched[t-15], 18) ^ (w_sched[t-15] >> 3))
                       + w_sched[t-16];
    endtask

    function automatic logic [255:0] ref_compress(input logic [255:0] hin);
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] res;
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int r = 0; r < 64; r++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tab[r] + w_sched[r];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return res;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v);
        in_valid = v;
        @(posedge clock);
        #1;
    endtask

    task automatic to_idle();
        enable = 1'b0;
        step(1'b0);
        enable = 1'b1;
    endtask

    // Start a block and feed rounds until hash_valid, watching round_index.
    task automatic run_block(input logic [255:0] hin, input bit rnd, input bit chk_r0,
                             output logic [255:0] dig, output int lat);
        int         idx_err;
        logic [5:0] idx_b;
        logic       v, acc, rdy_b;
        idx_err = 0;
        lat     = -1;
        h_in    = hin;
        start   = 1'b1;
        step(1'b0);
        start   = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            v     = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            idx_b = round_index;
            rdy_b = in_ready;
            acc   = v && rdy_b;
            step(v);
            if (chk_r0 && acc && idx_b == 6'd0) begin
                check("round0_a", 256'(dut.work_r[7]), 256'h5d6aebcd);
                check("round0_e", 256'(dut.work_r[3]), 256'hfa2a4622);
            end
            if (acc && idx_b != 6'd63 && round_index != 6'(idx_b + 6'd1)) idx_err++;
            if (rdy_b && !acc && round_index != idx_b) idx_err++;
            if (hash_valid) begin
                lat = cyc;
                break;
            end
        end
        check("index_advance", 256'(idx_err), 256'd0);
        check("hash_valid_seen", 256'(lat > 0), 256'd1);
        dig = hash_out;
        step(1'b0);
        check("hash_valid_pulse", 256'(hash_valid), 256'd0);
        check("round_complete_level", 256'(round_complete), 256'd1);
    endtask

    initial begin
        logic [255:0] dig, exp, snap, abc_dig;
        logic [511:0] blk;
        logic [5:0]   idx_snap;
        int           lat;

        // Reset state
        #17;
        check("rst_in_ready", 256'(in_ready), 256'd0);
        check("rst_round_index", 256'(round_index), 256'd0);
        check("rst_hash_out", hash_out, 256'd0);
        check("rst_hash_valid", 256'(hash_valid), 256'd0);
        check("rst_round_complete", 256'(round_complete), 256'd0);
        reset  = 1'b1;
        enable = 1'b1;
        step(1'b0);

        // "abc" with in_valid held high
        blk = '0;
        blk[511:480] = 32'h61626380;
        blk[31:0]    = 32'h00000018;
        set_block(blk);
        run_block(IV, 1'b0, 1'b1, abc_dig, lat);
        check("abc_digest", abc_dig, ABC_DIGEST);
        check("abc_latency", 256'(lat), 256'd66);

        // start in DONE is ignored; DONE holds until enable drops
        snap  = dut.work_r;
        start = 1'b1;
        step(1'b1);
        start = 1'b0;
        step(1'b1);
        check("done_start_work", dut.work_r, snap);
        check("done_start_ready", 256'(in_ready), 256'd0);
        check("done_start_rc", 256'(round_complete), 256'd1);
        check("done_start_hv", 256'(hash_valid), 256'd0);
        to_idle();
        check("idle_rc_clear", 256'(round_complete), 256'd0);
        check("idle_hash_hold", hash_out, ABC_DIGEST);

        // "abc" with random bubbles
        run_block(IV, 1'b1, 1'b0, dig, lat);
        check("abc_bubbles_digest", dig, ABC_DIGEST);
        to_idle();

        // start pulse mid-ROUND is ignored, then abort at round 30
        h_in  = IV;
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b1);
        snap     = dut.work_r;
        idx_snap = round_index;
        h_in     = rand256();
        start    = 1'b1;
        step(1'b0);
        start    = 1'b0;
        check("round_start_work", dut.work_r, snap);
        check("round_start_index", 256'(round_index), 256'(idx_snap));
        for (int i = 0; i < 64 && round_index != 6'd30; i++) step(1'b1);
        check("reach_round30", 256'(round_index), 256'd30);
        enable = 1'b0;
        step(1'b1);
        check("abort_index", 256'(round_index), 256'd0);
        check("abort_rc", 256'(round_complete), 256'd0);
        check("abort_hash_hold", hash_out, ABC_DIGEST);
        enable = 1'b1;
        #1;
        check("abort_is_idle", 256'(in_ready), 256'd0);
        run_block(IV, 1'b0, 1'b0, dig, lat);
        check("after_abort_digest", dig, ABC_DIGEST);
        to_idle();

        // Asynchronous reset mid-block
        h_in  = IV;
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("areset_index", 256'(round_index), 256'd0);
        check("areset_hash", hash_out, 256'd0);
        check("areset_ready", 256'(in_ready), 256'd0);
        check("areset_outs", 256'({hash_valid, round_complete}), 256'd0);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1);
        check("post_reset_index", 256'(round_index), 256'd0);
        check("post_reset_work", dut.work_r, 256'd0);

        // Chained second block starting from the "abc" digest
        blk = '0;
        blk[511:480] = 32'h80000000;
        set_block(blk);
        exp = ref_compress(abc_dig);
        run_block(abc_dig, 1'b1, 1'b0, dig, lat);
        check("chain_digest", dig, exp);
        to_idle();

        // Random chaining values and blocks
        for (int n = 0; n < 3; n++) begin
            h_in = rand256();
            blk  = {rand256(), rand256()};
            set_block(blk);
            exp  = ref_compress(h_in);
            run_block(h_in, 1'b1, 1'b0, dig, lat);
            check("random_digest", dig, exp);
            to_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
